// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: memory address/data, pipeline control and IF/ID latch
interface fetch_unit_if;
  logic [15:0] PC;
  logic [15:0] Instruction;
  logic        Stall;
  logic        Redirect;
  logic [15:0] RedirectTarget;
  logic [15:0] IR;
  logic [15:0] IR_PC;
  logic        IR_Valid;
  logic        Halted;
  logic [15:0] FetchCount;

  modport master (
    output PC, IR, IR_PC, IR_Valid, Halted, FetchCount,
    input  Instruction, Stall, Redirect, RedirectTarget
  );

  modport slave (
    input  PC, IR, IR_PC, IR_Valid, Halted, FetchCount,
    output Instruction, Stall, Redirect, RedirectTarget
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, IF/ID latch, stall/redirect/flush, halt and fetch counter
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] PC_STEP   = 16'd1,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic         Clock,
  input  logic         Reset,
  fetch_unit_if.master bus
);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic        ir_valid;
  logic [15:0] fetch_count;

  // Redirect outranks halt and stall so a taken branch always escapes HALT.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= S_RUN;
      pc          <= RESET_PC;
      ir          <= 16'h0000;
      ir_pc       <= 16'h0000;
      ir_valid    <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (bus.Redirect) begin
      state    <= S_RUN;
      pc       <= bus.RedirectTarget;
      ir       <= 16'h0000;
      ir_valid <= 1'b0;
    end else if (state == S_HALT) begin
      ir_valid <= 1'b0;
    end else if (!bus.Stall) begin
      ir          <= bus.Instruction;
      ir_pc       <= pc;
      ir_valid    <= 1'b1;
      pc          <= pc + PC_STEP;
      fetch_count <= fetch_count + 16'd1;
      if (bus.Instruction == HALT_WORD) begin
        state <= S_HALT;
      end
    end
  end

  assign bus.PC         = pc;
  assign bus.IR         = ir;
  assign bus.IR_PC      = ir_pc;
  assign bus.IR_Valid   = ir_valid;
  assign bus.Halted     = (state == S_HALT);
  assign bus.FetchCount = fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against an instruction-stream model
module tb_fetch_unit;

  logic Clock = 1'b0;
  logic Reset = 1'b0;
  logic [15:0] mem [0:65535];

  fetch_unit_if bus ();

  fetch_unit dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  assign bus.Instruction = mem[bus.PC];

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  logic [15:0] m_pc, m_ir, m_ir_pc, m_fc;
  logic        m_valid, m_halted;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 16'h0000; m_ir = 16'h0000; m_ir_pc = 16'h0000;
    m_fc = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
  endtask

  // Model: what the decoder should see after each edge, from the fetch rules.
  always @(posedge Clock) begin
    if (Reset) begin
      if (bus.Redirect) begin
        m_pc = bus.RedirectTarget; m_ir = 16'h0000; m_valid = 1'b0; m_halted = 1'b0;
      end else if (m_halted) begin
        m_valid = 1'b0;
      end else if (!bus.Stall) begin
        m_ir_pc = m_pc;
        m_ir    = mem[m_pc];
        m_valid = 1'b1;
        m_pc    = m_pc + 16'd1;
        m_fc    = m_fc + 16'd1;
        if (m_ir == 16'hFFFF) m_halted = 1'b1;
      end
    end
  end

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("cyc_pc",    bus.PC,                 m_pc);
      chk("cyc_ir",    bus.IR,                 m_ir);
      chk("cyc_ir_pc", bus.IR_PC,              m_ir_pc);
      chk("cyc_valid", {15'd0, bus.IR_Valid},  {15'd0, m_valid});
      chk("cyc_halt",  {15'd0, bus.Halted},    {15'd0, m_halted});
      chk("cyc_fc",    bus.FetchCount,         m_fc);
    end
  end

  task automatic tick();
    @(posedge Clock);
    @(negedge Clock);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_pc"},    bus.PC,                16'h0000);
    chk({tag, "_ir"},    bus.IR,                16'h0000);
    chk({tag, "_ir_pc"}, bus.IR_PC,             16'h0000);
    chk({tag, "_valid"}, {15'd0, bus.IR_Valid}, 16'h0000);
    chk({tag, "_halt"},  {15'd0, bus.Halted},   16'h0000);
    chk({tag, "_fc"},    bus.FetchCount,        16'h0000);
  endtask

  task automatic apply_reset();
    model_reset();
    Reset = 1'b0;
    #1;
    check_reset_values("rst");
    @(negedge Clock);
    #2;
    Reset = 1'b1;
  endtask

  initial begin
    bus.Stall = 1'b0;
    bus.Redirect = 1'b0;
    bus.RedirectTarget = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + i[15:0];
    model_reset();
    #1;
    cmp_en = 1'b1;

    // Free-run over the ramp
    apply_reset();
    tick();
    chk("run_e1_ir", bus.IR, 16'h1000);
    chk("run_e1_ir_pc", bus.IR_PC, 16'h0000);
    chk("run_e1_valid", {15'd0, bus.IR_Valid}, 16'h0001);
    chk("run_e1_pc", bus.PC, 16'h0001);
    repeat (4) tick();
    chk("run_e5_ir", bus.IR, 16'h1004);
    chk("run_e5_fc", bus.FetchCount, 16'h0005);

    // Stall for 3 cycles after edge 2
    apply_reset();
    repeat (2) tick();
    bus.Stall = 1'b1;
    repeat (3) tick();
    chk("stall_ir", bus.IR, 16'h1001);
    chk("stall_pc", bus.PC, 16'h0002);
    chk("stall_fc", bus.FetchCount, 16'h0002);
    bus.Stall = 1'b0;
    tick();
    chk("stall_rel_ir", bus.IR, 16'h1002);

    // Redirect with simultaneous stall
    bus.Redirect = 1'b1; bus.RedirectTarget = 16'h0040; bus.Stall = 1'b1;
    tick();
    chk("redir_pc", bus.PC, 16'h0040);
    chk("redir_valid", {15'd0, bus.IR_Valid}, 16'h0000);
    chk("redir_ir", bus.IR, 16'h0000);
    bus.Redirect = 1'b0; bus.Stall = 1'b0;
    tick();
    chk("redir_tgt_ir", bus.IR, 16'h1040);
    chk("redir_tgt_ir_pc", bus.IR_PC, 16'h0040);

    // Halt word at address 3
    mem[3] = 16'hFFFF;
    apply_reset();
    repeat (4) tick();
    chk("halt_ir", bus.IR, 16'hFFFF);
    chk("halt_valid", {15'd0, bus.IR_Valid}, 16'h0001);
    chk("halt_halted", {15'd0, bus.Halted}, 16'h0001);
    chk("halt_pc", bus.PC, 16'h0004);
    repeat (10) tick();
    chk("halt_hold_valid", {15'd0, bus.IR_Valid}, 16'h0000);
    chk("halt_hold_pc", bus.PC, 16'h0004);
    bus.Redirect = 1'b1; bus.RedirectTarget = 16'h0000;
    tick();
    chk("halt_exit_halted", {15'd0, bus.Halted}, 16'h0000);
    chk("halt_exit_pc", bus.PC, 16'h0000);
    bus.Redirect = 1'b0;
    tick();
    chk("halt_resume_ir", bus.IR, 16'h1000);
    chk("halt_resume_valid", {15'd0, bus.IR_Valid}, 16'h0001);

    // PC wrap at top of memory
    bus.Redirect = 1'b1; bus.RedirectTarget = 16'hFFFE;
    tick();
    bus.Redirect = 1'b0;
    repeat (2) tick();
    chk("wrap_pc", bus.PC, 16'h0000);
    chk("wrap_ir", bus.IR, 16'h0FFF);
    chk("wrap_ir_pc", bus.IR_PC, 16'hFFFF);

    // Async reset while IR_Valid=1 and Halted=1
    bus.Redirect = 1'b1; bus.RedirectTarget = 16'h0000;
    tick();
    bus.Redirect = 1'b0;
    repeat (4) tick();
    chk("async_pre_valid", {15'd0, bus.IR_Valid}, 16'h0001);
    chk("async_pre_halt", {15'd0, bus.Halted}, 16'h0001);
    #2;
    model_reset();
    Reset = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge Clock);
    #2;
    Reset = 1'b1;

    // FetchCount wrap over a halt-free memory image
    for (int i = 0; i < 65536; i++) mem[i] = {1'b0, i[14:0]};
    apply_reset();
    repeat (65535) tick();
    chk("fc_full", bus.FetchCount, 16'hFFFF);
    chk("fc_full_pc", bus.PC, 16'hFFFF);
    tick();
    chk("fc_wrap", bus.FetchCount, 16'h0000);
    chk("fc_wrap_pc", bus.PC, 16'h0000);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 16-bit CPU. It owns the program counter and drives the address into the combinational `instructionMemory`. It captures the returned word into an instruction register (IF/ID latch) for the decoder. It also handles pipeline stall, redirect (branch/jump) with flush, halt detection, and a retired-fetch counter.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `PC_STEP`, 16'd1, PC increment per fetched instruction (word-addressed memory).
- `HALT_WORD`, 16'hFFFF, instruction encoding that halts fetch.

Ports:
- `Clock`  in  1  system clock; all state updates on rising edge.
- `Reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `PC`  out  16  fetch address, drives `instructionMemory` address input.
- `Instruction`  in  16  word read from `instructionMemory` at `PC` (combinational, same cycle).
- `Stall`  in  1  decode/hazard stall; freeze PC and IF/ID contents.
- `Redirect`  in  1  taken branch/jump from execute; load new PC and flush.
- `RedirectTarget`  in  16  absolute target address when `Redirect`=1.
- `IR`  out  16  latched instruction to decoder.
- `IR_PC`  out  16  address the word in `IR` was fetched from.
- `IR_Valid`  out  1  `IR` holds a live instruction.
- `Halted`  out  1  fetch stopped on `HALT_WORD`.
- `FetchCount`  out  16  number of instructions latched since reset, wraps modulo 2^16.

## Operation
- State machine, two states:
  - RUN (reset state).
  - HALT, entered when a `HALT_WORD` is latched. It is left only by `Redirect` (to RUN) or reset.
- Per rising edge, with `Reset`=1, actions are evaluated in strict priority:
  1. `Redirect`=1 (any state, regardless of `Stall`):
     - PC<=RedirectTarget, IR<=16'h0000, IR_Valid<=0.
     - IR_PC unchanged, FetchCount unchanged, state<=RUN.
  2. State HALT: PC, IR, IR_PC and FetchCount hold; IR_Valid<=0.
  3. `Stall`=1: PC, IR, IR_PC, IR_Valid and FetchCount all hold.
  4. Otherwise (fetch):
     - IR<=Instruction, IR_PC<=PC, IR_Valid<=1.
     - PC<=PC+PC_STEP, truncated to 16 bits (16'hFFFF+1 wraps to 16'h0000).
     - FetchCount<=FetchCount+1, wraps.
     - If Instruction==HALT_WORD, state<=HALT.
- Halted is 1 exactly when state is HALT (registered, no combinational path from `Instruction`).
- The halt word itself is delivered to decode with IR_Valid=1 for one cycle. PC has already advanced past it.
- Reset (`Reset`=0, asynchronous, overrides everything, effective immediately without a clock edge):
  - PC=RESET_PC, IR=16'h0000, IR_PC=16'h0000.
  - IR_Valid=0, Halted=0, FetchCount=0, state RUN.

## Timing
- Fetch latency: the word at PC appears on IR one edge later, with IR_Valid=1.
- One instruction per cycle when not stalled.
- Redirect penalty: the edge that takes `Redirect` produces one bubble (IR_Valid=0). The target instruction is on IR after the following edge if not stalled.
- `Stall` and `Redirect` in the same cycle: the redirect is taken and the stall is ignored for that edge.
- A `Stall` held N cycles holds IR/IR_Valid for N edges. The first unstalled edge latches `Instruction` at the held PC.
- HALT_WORD fetched while `Stall`=1 is not latched; the halt takes effect only on the edge that latches it.
- Reset released between edges: the first edge after release performs a normal fetch at RESET_PC.
- PC is a registered output and is stable for a full cycle, so memory read time is one cycle minus setup.

## Test plan
- Reset then free-run: memory holds a ramp (word at address n = 16'h1000+n), `Stall`=`Redirect`=0.
  - After edge 1: IR=16'h1000, IR_PC=0, IR_Valid=1, PC=1.
  - After edge 5: IR=16'h1004, FetchCount=5.
- Stall: assert `Stall` for 3 cycles after edge 2.
  - IR stays 16'h1001, PC stays 2, FetchCount stays 2.
  - First edge after release gives IR=16'h1002.
- Redirect with simultaneous Stall: `Redirect`=1, RedirectTarget=16'h0040, `Stall`=1.
  - Next edge: PC=16'h0040, IR_Valid=0, IR=0.
  - Following edge: IR=word[0x40], IR_PC=16'h0040.
- Halt: place 16'hFFFF at address 3.
  - Edge latching it: IR=16'hFFFF, IR_Valid=1, Halted=1, PC=4.
  - Afterwards IR_Valid=0, PC holds at 4 for 10 cycles.
  - Then `Redirect` to 16'h0000 clears Halted and resumes fetch.
- Wrap: Redirect to 16'hFFFE (non-halt words there).
  - Two fetches give PC=16'h0000.
  - Preload FetchCount to 16'hFFFF via 65535 fetches; the next fetch gives FetchCount=0.
- Async reset mid-operation: drop `Reset` between clock edges while IR_Valid=1 and Halted=1.
  - All outputs go to reset values immediately, before the next edge.
